// File: rtl/arm7tdmi_tlb_multisize_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arm7tdmi_tlb_multisize_if                                                  |
// | Lookup/response, walker-fill, flush and statistics bundle for the TLB.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface arm7tdmi_tlb_multisize_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ASID_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
);
  logic                  lookup_valid;
  logic                  lookup_ready;
  logic [ADDR_WIDTH-1:0] lookup_vaddr;
  logic [ASID_WIDTH-1:0] lookup_asid;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [ADDR_WIDTH-1:0] resp_paddr;
  logic [1:0]            resp_size;
  logic [1:0]            resp_ap;
  logic [3:0]            resp_domain;
  logic [1:0]            resp_cb;
  logic                  fill_valid;
  logic [ADDR_WIDTH-1:0] fill_vaddr;
  logic [ADDR_WIDTH-1:0] fill_paddr;
  logic [1:0]            fill_size;
  logic [ASID_WIDTH-1:0] fill_asid;
  logic                  fill_global;
  logic [1:0]            fill_ap;
  logic [3:0]            fill_domain;
  logic [1:0]            fill_cb;
  logic                  flush_all;
  logic                  flush_va;
  logic [ADDR_WIDTH-1:0] flush_addr;
  logic                  flush_asid;
  logic [ASID_WIDTH-1:0] flush_asid_val;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  modport master (
    output lookup_valid, lookup_vaddr, lookup_asid,
    output fill_valid, fill_vaddr, fill_paddr, fill_size, fill_asid, fill_global,
    output fill_ap, fill_domain, fill_cb,
    output flush_all, flush_va, flush_addr, flush_asid, flush_asid_val,
    input  lookup_ready, resp_valid, resp_hit, resp_paddr, resp_size, resp_ap,
    input  resp_domain, resp_cb, busy, hit_count, miss_count
  );

  modport slave (
    input  lookup_valid, lookup_vaddr, lookup_asid,
    input  fill_valid, fill_vaddr, fill_paddr, fill_size, fill_asid, fill_global,
    input  fill_ap, fill_domain, fill_cb,
    input  flush_all, flush_va, flush_addr, flush_asid, flush_asid_val,
    output lookup_ready, resp_valid, resp_hit, resp_paddr, resp_size, resp_ap,
    output resp_domain, resp_cb, busy, hit_count, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/arm7tdmi_tlb_multisize.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arm7tdmi_tlb_multisize                                                     |
// | ASID-tagged fully-associative TLB holding section/large/small/tiny maps.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module arm7tdmi_tlb_multisize #(
  parameter int TLB_ENTRIES = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int ASID_WIDTH  = 8,
  parameter int CNT_WIDTH   = 32
) (
  input wire logic clk,
  input wire logic rst,
  arm7tdmi_tlb_multisize_if.slave bus
);
  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WALK = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Tags and PAs are kept full width with the page-offset bits forced to zero.
  logic                  valid_q  [TLB_ENTRIES];
  logic                  valid_d  [TLB_ENTRIES];
  logic [ADDR_WIDTH-1:0] tag_q    [TLB_ENTRIES];
  logic [ADDR_WIDTH-1:0] tag_d    [TLB_ENTRIES];
  logic [ADDR_WIDTH-1:0] pa_q     [TLB_ENTRIES];
  logic [ADDR_WIDTH-1:0] pa_d     [TLB_ENTRIES];
  logic [1:0]            size_q   [TLB_ENTRIES];
  logic [1:0]            size_d   [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0] asid_q   [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0] asid_d   [TLB_ENTRIES];
  logic                  global_q [TLB_ENTRIES];
  logic                  global_d [TLB_ENTRIES];
  logic [1:0]            ap_q     [TLB_ENTRIES];
  logic [1:0]            ap_d     [TLB_ENTRIES];
  logic [3:0]            dom_q    [TLB_ENTRIES];
  logic [3:0]            dom_d    [TLB_ENTRIES];
  logic [1:0]            cb_q     [TLB_ENTRIES];
  logic [1:0]            cb_d     [TLB_ENTRIES];

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      walk_idx_q, walk_idx_d;
  logic [ASID_WIDTH-1:0] walk_asid_q, walk_asid_d;
  logic [IDX_W-1:0]      rr_q, rr_d;

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [ADDR_WIDTH-1:0] resp_paddr_q, resp_paddr_d;
  logic [1:0]            resp_size_q, resp_size_d;
  logic [1:0]            resp_ap_q, resp_ap_d;
  logic [3:0]            resp_domain_q, resp_domain_d;
  logic [1:0]            resp_cb_q, resp_cb_d;
  logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

  logic                  busy;
  logic                  lookup_fire;
  logic                  lk_hit;
  logic [IDX_W-1:0]      lk_idx;
  logic [ADDR_WIDTH-1:0] lk_mask;
  logic [ADDR_WIDTH-1:0] fill_tag;
  logic [ADDR_WIDTH-1:0] fill_mask;
  logic                  fill_same, fill_free, fill_use_rr;
  logic [IDX_W-1:0]      fill_same_idx, fill_free_idx, fill_idx;

  function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = {ADDR_WIDTH{1'b1}} << 20;
      2'b01:   size_mask = {ADDR_WIDTH{1'b1}} << 16;
      2'b10:   size_mask = {ADDR_WIDTH{1'b1}} << 12;
      default: size_mask = {ADDR_WIDTH{1'b1}} << 10;
    endcase
  endfunction

  assign busy        = (state_q == ST_WALK);
  assign lookup_fire = bus.lookup_valid && !busy;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && ((bus.lookup_vaddr & size_mask(size_q[i])) == tag_q[i]) &&
          (global_q[i] || (asid_q[i] == bus.lookup_asid))) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lk_mask       = size_mask(size_q[lk_idx]);
    resp_valid_d  = lookup_fire;
    resp_hit_d    = lookup_fire && lk_hit;
    resp_paddr_d  = '0;
    resp_size_d   = '0;
    resp_ap_d     = '0;
    resp_domain_d = '0;
    resp_cb_d     = '0;
    if (resp_hit_d) begin
      resp_paddr_d  = (pa_q[lk_idx] & lk_mask) | (bus.lookup_vaddr & ~lk_mask);
      resp_size_d   = size_q[lk_idx];
      resp_ap_d     = ap_q[lk_idx];
      resp_domain_d = dom_q[lk_idx];
      resp_cb_d     = cb_q[lk_idx];
    end
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (lookup_fire && lk_hit && (hit_count_q != CNT_MAX))
      hit_count_d = hit_count_q + CNT_WIDTH'(1);
    if (lookup_fire && !lk_hit && (miss_count_q != CNT_MAX))
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
  end

  // Fill target: exact remap first, then lowest free slot, then round-robin victim.
  always_comb begin
    fill_mask     = size_mask(bus.fill_size);
    fill_tag      = bus.fill_vaddr & fill_mask;
    fill_same     = 1'b0;
    fill_same_idx = '0;
    fill_free     = 1'b0;
    fill_free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (size_q[i] == bus.fill_size) && (tag_q[i] == fill_tag) &&
          (global_q[i] ? bus.fill_global
                       : (!bus.fill_global && (asid_q[i] == bus.fill_asid)))) begin
        fill_same     = 1'b1;
        fill_same_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        fill_free     = 1'b1;
        fill_free_idx = IDX_W'(i);
      end
    end
    fill_use_rr = !fill_same && !fill_free;
    if (fill_same)      fill_idx = fill_same_idx;
    else if (fill_free) fill_idx = fill_free_idx;
    else                fill_idx = rr_q;
  end

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    pa_d        = pa_q;
    size_d      = size_q;
    asid_d      = asid_q;
    global_d    = global_q;
    ap_d        = ap_q;
    dom_d       = dom_q;
    cb_d        = cb_q;
    state_d     = state_q;
    walk_idx_d  = walk_idx_q;
    walk_asid_d = walk_asid_q;
    rr_d        = rr_q;
    if (bus.flush_all) begin
      for (int i = 0; i < TLB_ENTRIES; i++) valid_d[i] = 1'b0;
      rr_d       = '0;
      state_d    = ST_IDLE;
      walk_idx_d = '0;
    end else if (state_q == ST_WALK) begin
      if (!global_q[walk_idx_q] && (asid_q[walk_idx_q] == walk_asid_q))
        valid_d[walk_idx_q] = 1'b0;
      if (walk_idx_q == LAST_IDX) begin
        state_d    = ST_IDLE;
        walk_idx_d = '0;
      end else begin
        walk_idx_d = walk_idx_q + IDX_W'(1);
      end
    end else if (bus.flush_asid) begin
      state_d     = ST_WALK;
      walk_idx_d  = '0;
      walk_asid_d = bus.flush_asid_val;
    end else if (bus.flush_va) begin
      for (int i = 0; i < TLB_ENTRIES; i++)
        if ((bus.flush_addr & size_mask(size_q[i])) == tag_q[i]) valid_d[i] = 1'b0;
    end else if (bus.fill_valid) begin
      valid_d[fill_idx]  = 1'b1;
      tag_d[fill_idx]    = fill_tag;
      pa_d[fill_idx]     = bus.fill_paddr & fill_mask;
      size_d[fill_idx]   = bus.fill_size;
      asid_d[fill_idx]   = bus.fill_asid;
      global_d[fill_idx] = bus.fill_global;
      ap_d[fill_idx]     = bus.fill_ap;
      dom_d[fill_idx]    = bus.fill_domain;
      cb_d[fill_idx]     = bus.fill_cb;
      if (fill_use_rr) rr_d = (rr_q == LAST_IDX) ? '0 : rr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        pa_q[i]     <= '0;
        size_q[i]   <= '0;
        asid_q[i]   <= '0;
        global_q[i] <= 1'b0;
        ap_q[i]     <= '0;
        dom_q[i]    <= '0;
        cb_q[i]     <= '0;
      end
      state_q       <= ST_IDLE;
      walk_idx_q    <= '0;
      walk_asid_q   <= '0;
      rr_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_paddr_q  <= '0;
      resp_size_q   <= '0;
      resp_ap_q     <= '0;
      resp_domain_q <= '0;
      resp_cb_q     <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      pa_q          <= pa_d;
      size_q        <= size_d;
      asid_q        <= asid_d;
      global_q      <= global_d;
      ap_q          <= ap_d;
      dom_q         <= dom_d;
      cb_q          <= cb_d;
      state_q       <= state_d;
      walk_idx_q    <= walk_idx_d;
      walk_asid_q   <= walk_asid_d;
      rr_q          <= rr_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_paddr_q  <= resp_paddr_d;
      resp_size_q   <= resp_size_d;
      resp_ap_q     <= resp_ap_d;
      resp_domain_q <= resp_domain_d;
      resp_cb_q     <= resp_cb_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign bus.lookup_ready = !busy;
  assign bus.busy         = busy;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.resp_paddr   = resp_paddr_q;
  assign bus.resp_size    = resp_size_q;
  assign bus.resp_ap      = resp_ap_q;
  assign bus.resp_domain  = resp_domain_q;
  assign bus.resp_cb      = resp_cb_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.miss_count   = miss_count_q;
endmodule
`default_nettype wire

// File: tb/tb_arm7tdmi_tlb_multisize.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arm7tdmi_tlb_multisize                                                  |
// | Directed self-checking bench: 8 entries, 4-bit counters to hit saturation. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_arm7tdmi_tlb_multisize;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int SW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  logic [1:0] last_ap;
  logic [3:0] last_dom;
  logic [1:0] last_cb;

  arm7tdmi_tlb_multisize_if #(.ADDR_WIDTH(AW), .ASID_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  arm7tdmi_tlb_multisize #(
    .TLB_ENTRIES(N), .ADDR_WIDTH(AW), .ASID_WIDTH(SW), .CNT_WIDTH(CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    bus.lookup_valid = 1'b0; bus.lookup_vaddr = '0; bus.lookup_asid = '0;
    bus.fill_valid = 1'b0; bus.fill_vaddr = '0; bus.fill_paddr = '0; bus.fill_size = '0;
    bus.fill_asid = '0; bus.fill_global = 1'b0; bus.fill_ap = '0; bus.fill_domain = '0;
    bus.fill_cb = '0; bus.flush_all = 1'b0; bus.flush_va = 1'b0; bus.flush_addr = '0;
    bus.flush_asid = 1'b0; bus.flush_asid_val = '0;
  endtask

  // Called at a negedge; leaves the fill request driven for exactly one edge.
  task automatic do_fill(input logic [31:0] va, input logic [31:0] pa, input logic [1:0] sz,
                         input logic [7:0] asid, input logic glob, input logic [7:0] attr);
    bus.fill_valid = 1'b1; bus.fill_vaddr = va; bus.fill_paddr = pa; bus.fill_size = sz;
    bus.fill_asid = asid; bus.fill_global = glob;
    {bus.fill_ap, bus.fill_domain, bus.fill_cb} = attr;
    @(negedge clk);
    bus.fill_valid = 1'b0;
  endtask

  task automatic pulse_flush_all();
    bus.flush_all = 1'b1;
    @(negedge clk);
    bus.flush_all = 1'b0;
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] va, input logic [7:0] asid,
                              input logic exp_hit, input logic [31:0] exp_pa,
                              input logic [1:0] exp_sz);
    bus.lookup_valid = 1'b1; bus.lookup_vaddr = va; bus.lookup_asid = asid;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    check({tag, ".valid"}, 64'(bus.resp_valid), 64'd1);
    check({tag, ".hit"}, 64'(bus.resp_hit), 64'(exp_hit));
    check({tag, ".paddr"}, 64'(bus.resp_paddr), exp_hit ? 64'(exp_pa) : 64'd0);
    if (exp_hit) begin
      check({tag, ".size"}, 64'(bus.resp_size), 64'(exp_sz));
      exp_hits = (exp_hits == 15) ? 15 : exp_hits + 1;
    end else begin
      exp_misses = (exp_misses == 15) ? 15 : exp_misses + 1;
    end
    last_ap = bus.resp_ap; last_dom = bus.resp_domain; last_cb = bus.resp_cb;
  endtask

  initial begin
    int  cyc;
    logic stall_bad;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst.ready", 64'(bus.lookup_ready), 64'd1);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst.hit_count", 64'(bus.hit_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Section mapping with attributes.
    do_fill(32'h1230_0000, 32'h8000_0000, 2'b00, 8'd1, 1'b0, {2'b11, 4'hA, 2'b10});
    check_lookup("sect", 32'h1234_5678, 8'd1, 1'b1, 32'h8004_5678, 2'b00);
    check("sect.attr", 64'({last_ap, last_dom, last_cb}), 64'({2'b11, 4'hA, 2'b10}));
    check("sect.hit_count", 64'(bus.hit_count), 64'd1);

    // Small and tiny pages overlapping in VA, split by ASID; plus a large page.
    do_fill(32'h5001_1000, 32'h0020_1000, 2'b10, 8'd1, 1'b0, 8'h00);
    do_fill(32'h5001_1400, 32'h0030_0400, 2'b11, 8'd2, 1'b0, 8'h00);
    do_fill(32'h7FFF_0000, 32'h1234_0000, 2'b01, 8'd1, 1'b0, 8'h00);
    check_lookup("tiny", 32'h5001_1404, 8'd2, 1'b1, 32'h0030_0404, 2'b11);
    check_lookup("asid3", 32'h5001_1404, 8'd3, 1'b0, 32'h0, 2'b00);
    check("asid3.miss_count", 64'(bus.miss_count), 64'd1);
    check_lookup("small", 32'h5001_1404, 8'd1, 1'b1, 32'h0020_1404, 2'b10);
    check_lookup("large", 32'h7FFF_ABCD, 8'd1, 1'b1, 32'h1234_ABCD, 2'b01);

    // Nine small pages into eight entries; then an exact remap and a second victim.
    pulse_flush_all();
    for (int k = 1; k <= 9; k++)
      do_fill(32'(k) << 12, 32'h0100_0000 + (32'(k) << 12), 2'b10, 8'd1, 1'b0, 8'h00);
    check_lookup("evict0", 32'h0000_1000, 8'd1, 1'b0, 32'h0, 2'b00);
    check_lookup("ninth", 32'h0000_9123, 8'd1, 1'b1, 32'h0100_9123, 2'b10);
    do_fill(32'h0000_4000, 32'hAAAA_0000, 2'b10, 8'd1, 1'b0, 8'h00);
    do_fill(32'h0000_A000, 32'h0200_A000, 2'b10, 8'd1, 1'b0, 8'h00);
    check_lookup("remap", 32'h0000_4010, 8'd1, 1'b1, 32'hAAAA_0010, 2'b10);
    check_lookup("evict1", 32'h0000_2000, 8'd1, 1'b0, 32'h0, 2'b00);
    check_lookup("keep2", 32'h0000_3000, 8'd1, 1'b1, 32'h0100_3000, 2'b10);

    // ASID flush walk with lookups held pending throughout.
    pulse_flush_all();
    do_fill(32'h0010_0000, 32'h00A0_0000, 2'b00, 8'd0, 1'b1, 8'h00);
    do_fill(32'h0020_0000, 32'h00B0_0000, 2'b10, 8'd5, 1'b0, 8'h00);
    do_fill(32'h0030_0000, 32'h00C0_0000, 2'b10, 8'd6, 1'b0, 8'h00);
    bus.flush_asid = 1'b1; bus.flush_asid_val = 8'd5;
    @(negedge clk);
    bus.flush_asid = 1'b0; bus.flush_asid_val = 8'd0;
    check("walk.ready", 64'(bus.lookup_ready), 64'd0);
    cyc = 0; stall_bad = 1'b0;
    while (bus.busy && cyc < 20) begin
      cyc++;
      bus.lookup_valid = 1'b1; bus.lookup_vaddr = 32'h0010_0000; bus.lookup_asid = 8'd9;
      @(negedge clk);
      if (bus.resp_valid) stall_bad = 1'b1;
    end
    bus.lookup_valid = 1'b0;
    check("walk.busy_cycles", 64'(cyc), 64'd8);
    check("walk.stalled", 64'(stall_bad), 64'd0);
    check("walk.hit_count_held", 64'(bus.hit_count), 64'(exp_hits));
    check_lookup("walk.asid5", 32'h0020_0000, 8'd5, 1'b0, 32'h0, 2'b00);
    check_lookup("walk.global", 32'h0010_0040, 8'd7, 1'b1, 32'h00A0_0040, 2'b00);
    check_lookup("walk.asid6", 32'h0030_0044, 8'd6, 1'b1, 32'h00C0_0044, 2'b10);

    // flush_all aborts a walk in progress.
    bus.flush_asid = 1'b1; bus.flush_asid_val = 8'd6;
    @(negedge clk);
    bus.flush_asid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort.busy_before", 64'(bus.busy), 64'd1);
    pulse_flush_all();
    check("abort.busy_after", 64'(bus.busy), 64'd0);
    check_lookup("abort.cleared", 32'h0010_0000, 8'd0, 1'b0, 32'h0, 2'b00);

    // Same-cycle fill is not visible to the lookup; flush_va is selective.
    do_fill(32'h5555_5000, 32'h0666_6000, 2'b10, 8'd1, 1'b0, 8'h00);
    bus.fill_valid = 1'b1; bus.fill_vaddr = 32'h1230_0000; bus.fill_paddr = 32'h8000_0000;
    bus.fill_size = 2'b00; bus.fill_asid = 8'd1; bus.fill_global = 1'b0;
    check_lookup("same_cycle", 32'h1234_5678, 8'd1, 1'b0, 32'h0, 2'b00);
    bus.fill_valid = 1'b0;
    check_lookup("next_cycle", 32'h1234_5678, 8'd1, 1'b1, 32'h8004_5678, 2'b00);
    bus.flush_va = 1'b1; bus.flush_addr = 32'h1230_0000;
    @(negedge clk);
    bus.flush_va = 1'b0;
    check_lookup("flush_va", 32'h1234_5678, 8'd1, 1'b0, 32'h0, 2'b00);
    check_lookup("flush_va.other", 32'h5555_5ABC, 8'd1, 1'b1, 32'h0666_6ABC, 2'b10);

    // Saturation of the 4-bit hit counter.
    for (int k = 0; k < 20; k++) begin
      bus.lookup_valid = 1'b1; bus.lookup_vaddr = 32'h5555_5000; bus.lookup_asid = 8'd1;
      @(negedge clk);
    end
    bus.lookup_valid = 1'b0;
    @(negedge clk);
    check("sat.hit_count", 64'(bus.hit_count), 64'hF);
    check("sat.miss_count", 64'(bus.miss_count), 64'(exp_misses));

    // Async reset returns everything to the reset state.
    rst = 1'b1;
    #2;
    check("rst2.hit_count", 64'(bus.hit_count), 64'd0);
    check("rst2.ready", 64'(bus.lookup_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_lookup("rst2.empty", 32'h5555_5000, 8'd1, 1'b0, 32'h0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
